// File: rtl/verinject_campaign_sequencer_pkg.sv
// Shared types and constants for the fault-injection campaign sequencer.
package verinject_campaign_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StRun,
        StInject,
        StObserve,
        StRecord,
        StDone
    } state_e;

    localparam logic [31:0] NO_INJECT      = 32'hFFFF_FFFF;
    localparam int unsigned DEF_TOTAL_BITS = 24584;
    localparam int unsigned DEF_CYCLE_W    = 48;

endpackage

// File: rtl/verinject_campaign_sequencer_if.sv
// Control/status bundle between the campaign sequencer and its driver.
interface verinject_campaign_sequencer_if #(
    parameter int unsigned CYCLE_W = 48
);
    logic               start;
    logic               abort;
    logic [CYCLE_W-1:0] inject_cycle;
    logic [15:0]        window_len;
    logic               mismatch;
    logic               dut_reset;
    logic [31:0]        verinject__injector_state;
    logic [CYCLE_W-1:0] cycle_number;
    logic [31:0]        cur_bit;
    logic [31:0]        fail_count;
    logic               golden_err;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, inject_cycle, window_len, mismatch,
        input  dut_reset, verinject__injector_state, cycle_number, cur_bit, fail_count,
               golden_err, busy, done
    );

    modport slave (
        input  start, abort, inject_cycle, window_len, mismatch,
        output dut_reset, verinject__injector_state, cycle_number, cur_bit, fail_count,
               golden_err, busy, done
    );
endinterface

// File: rtl/verinject_campaign_sequencer_run_timer.sv
// Run-relative cycle counter, injection-point compare and observe-window down-counter.
module verinject_run_timer #(
    parameter int unsigned CYCLE_W = 48
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               cnt_en_i,
    input  logic               win_load_i,
    input  logic               win_dec_i,
    input  logic [CYCLE_W-1:0] inject_cycle_i,
    input  logic [15:0]        win_len_i,
    output logic [CYCLE_W-1:0] cycle_o,
    output logic               inject_next_o,
    output logic               win_last_o
);
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [15:0]        win_cnt_q, win_cnt_d;

    always_comb begin
        cycle_d = cycle_q;
        if (clr_i) begin
            cycle_d = '0;
        end else if (cnt_en_i) begin
            cycle_d = cycle_q + CYCLE_W'(1);
        end

        win_cnt_d = win_cnt_q;
        if (win_load_i) begin
            win_cnt_d = win_len_i;
        end else if (win_dec_i) begin
            win_cnt_d = win_cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q   <= '0;
            win_cnt_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    // Looks one cycle ahead so INJECT is entered showing cycle == inject_cycle.
    assign inject_next_o = ((cycle_q + CYCLE_W'(1)) == inject_cycle_i);
    assign win_last_o    = (win_cnt_q == 16'd1);
    assign cycle_o       = cycle_q;
endmodule

// File: rtl/verinject_campaign_sequencer.sv
// Walks every injectable bit: reset target, run to the flip cycle, flip, observe, record.
module verinject_campaign_sequencer
    import verinject_campaign_sequencer_pkg::*;
#(
    parameter int unsigned TOTAL_BITS = DEF_TOTAL_BITS,
    parameter int unsigned CYCLE_W    = DEF_CYCLE_W,
    parameter int unsigned RST_CYCLES = 4
) (
    input logic                          clock,
    input logic                          reset,
    verinject_campaign_sequencer_if.slave bus
);
    state_e             state_q, state_d;
    logic [31:0]        cur_bit_q, cur_bit_d;
    logic [31:0]        fail_q, fail_d;
    logic               gerr_q, gerr_d;
    logic               hit_q, hit_d;
    logic [CYCLE_W-1:0] inj_cyc_q, inj_cyc_d;
    logic [15:0]        win_len_q, win_len_d;
    logic [31:0]        rst_cnt_q, rst_cnt_d;
    logic               inject_next, win_last;

    always_comb begin
        state_d   = state_q;
        cur_bit_d = cur_bit_q;
        fail_d    = fail_q;
        gerr_d    = gerr_q;
        hit_d     = hit_q;
        inj_cyc_d = inj_cyc_q;
        win_len_d = win_len_q;
        rst_cnt_d = '0;

        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        inj_cyc_d = bus.inject_cycle;
                        win_len_d = (bus.window_len == 16'd0) ? 16'd1 : bus.window_len;
                        cur_bit_d = '0;
                        fail_d    = '0;
                        gerr_d    = 1'b0;
                        hit_d     = 1'b0;
                        state_d   = StRst;
                    end
                end
                StRst: begin
                    if (bus.mismatch) gerr_d = 1'b1;
                    if (rst_cnt_q == 32'(RST_CYCLES - 1)) begin
                        state_d = (inj_cyc_q == '0) ? StInject : StRun;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 32'd1;
                    end
                end
                StRun: begin
                    if (bus.mismatch) gerr_d = 1'b1;
                    if (inject_next) state_d = StInject;
                end
                StInject: begin
                    if (bus.mismatch) hit_d = 1'b1;
                    state_d = StObserve;
                end
                StObserve: begin
                    if (bus.mismatch) hit_d = 1'b1;
                    if (win_last) state_d = StRecord;
                end
                StRecord: begin
                    if (hit_q && (fail_q != 32'hFFFF_FFFF)) fail_d = fail_q + 32'd1;
                    hit_d = 1'b0;
                    if (cur_bit_q == 32'(TOTAL_BITS - 1)) begin
                        state_d = StDone;
                    end else begin
                        cur_bit_d = cur_bit_q + 32'd1;
                        state_d   = StRst;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cur_bit_q <= '0;
            fail_q    <= '0;
            gerr_q    <= 1'b0;
            hit_q     <= 1'b0;
            inj_cyc_q <= '0;
            win_len_q <= 16'd1;
            rst_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_bit_q <= cur_bit_d;
            fail_q    <= fail_d;
            gerr_q    <= gerr_d;
            hit_q     <= hit_d;
            inj_cyc_q <= inj_cyc_d;
            win_len_q <= win_len_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    verinject_run_timer #(
        .CYCLE_W(CYCLE_W)
    ) u_run_timer (
        .clock         (clock),
        .reset         (reset),
        .clr_i         (state_q == StRst),
        .cnt_en_i      (!bus.abort && (state_q inside {StRun, StInject, StObserve})),
        .win_load_i    (state_q == StInject),
        .win_dec_i     (state_q == StObserve),
        .inject_cycle_i(inj_cyc_q),
        .win_len_i     (win_len_q),
        .cycle_o       (bus.cycle_number),
        .inject_next_o (inject_next),
        .win_last_o    (win_last)
    );

    assign bus.dut_reset                 = (state_q == StRst);
    assign bus.verinject__injector_state = (state_q == StInject) ? cur_bit_q : NO_INJECT;
    assign bus.cur_bit                   = cur_bit_q;
    assign bus.fail_count                = fail_q;
    assign bus.golden_err                = gerr_q;
    assign bus.busy                      = (state_q != StIdle) && (state_q != StDone);
    assign bus.done                      = (state_q == StDone);
endmodule
